// File: rtl/core_pipe_pkg.sv
// Shared definitions for the RV32 inter-stage pipeline registers:
// occupancy state encodings, per-stage control widths and control-bit indices.
package core_pipe_pkg;

  typedef logic [1:0] pipe_state_t;

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_TWO   = 2'd2;

  localparam int IFID_CTRL_W  = 2;
  localparam int IDEX_CTRL_W  = 10;
  localparam int EXMEM_CTRL_W = 6;
  localparam int MEMWB_CTRL_W = 3;

  localparam int EXMEM_REGWRITE    = 0;
  localparam int EXMEM_MEMREAD     = 1;
  localparam int EXMEM_MEMWRITE    = 2;
  localparam int EXMEM_MEMTOREG_LO = 3;
  localparam int EXMEM_MEMTOREG_HI = 4;
  localparam int EXMEM_WORDBYTE    = 5;

  // A stage can take a new entry unless both slots are occupied.
  function automatic logic state_has_room(input pipe_state_t st);
    return st != ST_TWO;
  endfunction

endpackage

// File: rtl/pipe_slot.sv
// One pipeline entry: valid flag, payload and control field.
// Clear drops the entry and zeroes control but keeps the payload bits.
module pipe_slot #(
  parameter int DATA_W = 64,
  parameter int CTRL_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_load,
  input  logic              i_clear,
  input  logic [DATA_W-1:0] i_data,
  input  logic [CTRL_W-1:0] i_ctrl,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data,
  output logic [CTRL_W-1:0] o_ctrl
);

  logic              r_valid;
  logic [DATA_W-1:0] r_data;
  logic [CTRL_W-1:0] r_ctrl;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_ctrl  <= '0;
    end else if (i_clear) begin
      r_valid <= 1'b0;
      r_ctrl  <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
      r_ctrl  <= i_ctrl;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_ctrl  = r_ctrl;

endmodule

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with valid/ready handshake, optional two-entry
// skid buffer (registered in_ready), synchronous flush and NOP bubbles.
//   state    | meaning
//   ST_EMPTY | no entry held
//   ST_ONE   | main slot holds the entry presented downstream
//   ST_TWO   | main and skid slots full, upstream stalled
module pipe_stage_reg
  import core_pipe_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int CTRL_W = 8,
  parameter bit SKID   = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl
);

  pipe_state_t       r_state;
  pipe_state_t       w_state_nxt;
  logic              r_in_ready;

  logic              w_accept;
  logic              w_emit;
  logic              w_main_load;
  logic              w_main_clear;
  logic              w_skid_load;
  logic              w_skid_clear;
  logic              w_take_skid;

  logic              w_main_valid;
  logic [DATA_W-1:0] w_main_data;
  logic [CTRL_W-1:0] w_main_ctrl;
  logic              w_skid_valid;
  logic [DATA_W-1:0] w_skid_data;
  logic [CTRL_W-1:0] w_skid_ctrl;
  logic [DATA_W-1:0] w_main_src_data;
  logic [CTRL_W-1:0] w_main_src_ctrl;

  generate
    if (SKID) begin : g_rdy_reg
      assign in_ready = r_in_ready & ~reset;
    end else begin : g_rdy_comb
      assign in_ready = (~w_main_valid | out_ready) & ~reset;
    end
  endgenerate

  assign w_accept = in_valid & in_ready;
  assign w_emit   = w_main_valid & out_ready;

  // Without a skid slot, accept in ST_ONE implies emit, so ST_TWO is unreachable.
  always_comb begin
    w_state_nxt  = r_state;
    w_main_load  = 1'b0;
    w_skid_load  = 1'b0;
    w_skid_clear = 1'b0;
    case (r_state)
      ST_EMPTY: begin
        if (w_accept) begin
          w_state_nxt = ST_ONE;
          w_main_load = 1'b1;
        end
      end
      ST_ONE: begin
        if (w_accept && w_emit) begin
          w_main_load = 1'b1;
        end else if (w_accept) begin
          w_skid_load = SKID;
          w_state_nxt = ST_TWO;
        end else if (w_emit) begin
          w_state_nxt = ST_EMPTY;
        end
      end
      ST_TWO: begin
        if (w_emit) begin
          w_main_load  = 1'b1;
          w_skid_clear = 1'b1;
          w_state_nxt  = ST_ONE;
        end
      end
      default: w_state_nxt = ST_EMPTY;
    endcase
    if (flush) begin
      w_state_nxt  = ST_EMPTY;
      w_skid_clear = 1'b1;
    end
  end

  assign w_main_clear    = flush | (w_emit & ~w_main_load);
  assign w_take_skid     = (r_state == ST_TWO) & w_skid_valid;
  assign w_main_src_data = w_take_skid ? w_skid_data : in_data;
  assign w_main_src_ctrl = w_take_skid ? w_skid_ctrl : in_ctrl;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_EMPTY;
      r_in_ready <= 1'b1;
    end else begin
      r_state    <= w_state_nxt;
      r_in_ready <= state_has_room(w_state_nxt);
    end
  end

  pipe_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_main (
    .clk     (clk),
    .reset   (reset),
    .i_load  (w_main_load),
    .i_clear (w_main_clear),
    .i_data  (w_main_src_data),
    .i_ctrl  (w_main_src_ctrl),
    .o_valid (w_main_valid),
    .o_data  (w_main_data),
    .o_ctrl  (w_main_ctrl)
  );

  generate
    if (SKID) begin : g_skid
      pipe_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_skid (
        .clk     (clk),
        .reset   (reset),
        .i_load  (w_skid_load),
        .i_clear (w_skid_clear),
        .i_data  (in_data),
        .i_ctrl  (in_ctrl),
        .o_valid (w_skid_valid),
        .o_data  (w_skid_data),
        .o_ctrl  (w_skid_ctrl)
      );
    end else begin : g_no_skid
      assign w_skid_valid = 1'b0;
      assign w_skid_data  = '0;
      assign w_skid_ctrl  = '0;
    end
  endgenerate

  assign out_valid = w_main_valid;
  assign out_data  = w_main_data;
  assign out_ctrl  = w_main_valid ? w_main_ctrl : '0;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: SKID=0 and SKID=1 instances side by side, directed
// scenarios plus a randomized run against a FIFO reference model.
module tb_pipe_stage_reg;

  localparam int DW = 32;
  localparam int CW = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst       [2];
  logic          flush     [2];
  logic          in_valid  [2];
  logic          in_ready  [2];
  logic [DW-1:0] in_data   [2];
  logic [CW-1:0] in_ctrl   [2];
  logic          out_valid [2];
  logic          out_ready [2];
  logic [DW-1:0] out_data  [2];
  logic [CW-1:0] out_ctrl  [2];

  int errors = 0;
  int checks = 0;

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(1'b0)) u_dut0 (
    .clk(clk), .reset(rst[0]), .flush(flush[0]),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]), .in_ctrl(in_ctrl[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(out_data[0]), .out_ctrl(out_ctrl[0])
  );

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(1'b1)) u_dut1 (
    .clk(clk), .reset(rst[1]), .flush(flush[1]),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]), .in_ctrl(in_ctrl[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(out_data[1]), .out_ctrl(out_ctrl[1])
  );

  // Two reset cycles; returns at the negedge where reset has just been released.
  task automatic apply_reset(input int s);
    @(negedge clk);
    rst[s] = 1'b1; flush[s] = 1'b0; in_valid[s] = 1'b0; out_ready[s] = 1'b0;
    in_data[s] = '0; in_ctrl[s] = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst[s] = 1'b0;
  endtask

  task automatic test_reset(input int s);
    @(negedge clk);
    rst[s] = 1'b1; flush[s] = 1'b0; in_valid[s] = 1'b0; out_ready[s] = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    checks++; if (in_ready[s] !== 1'b0) begin errors++; $display("FAIL reset_rdy_during skid=%0d got=%b exp=0", s, in_ready[s]); end
    checks++; if (out_valid[s] !== 1'b0) begin errors++; $display("FAIL reset_valid skid=%0d got=%b exp=0", s, out_valid[s]); end
    checks++; if (out_ctrl[s] !== '0) begin errors++; $display("FAIL reset_ctrl skid=%0d got=%h exp=0", s, out_ctrl[s]); end
    checks++; if (out_data[s] !== '0) begin errors++; $display("FAIL reset_data skid=%0d got=%h exp=0", s, out_data[s]); end
    rst[s] = 1'b0;
    @(negedge clk); #1;
    checks++; if (in_ready[s] !== 1'b1) begin errors++; $display("FAIL reset_rdy_after skid=%0d got=%b exp=1", s, in_ready[s]); end
    checks++; if (out_valid[s] !== 1'b0) begin errors++; $display("FAIL reset_idle_valid skid=%0d got=%b exp=0", s, out_valid[s]); end
  endtask

  task automatic test_stream(input int s);
    logic [DW-1:0] d [3];
    d[0] = 32'h0F; d[1] = 32'h14; d[2] = 32'h05;
    apply_reset(s);
    out_ready[s] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (k < 3) begin
        in_valid[s] = 1'b1; in_data[s] = d[k]; in_ctrl[s] = 6'h21;
      end else begin
        in_valid[s] = 1'b0;
      end
      #1;
      if (k < 3) begin
        checks++; if (in_ready[s] !== 1'b1) begin errors++; $display("FAIL stream_rdy skid=%0d k=%0d got=%b exp=1", s, k, in_ready[s]); end
      end
      if (k == 0) begin
        checks++; if (out_valid[s] !== 1'b0) begin errors++; $display("FAIL stream_first_valid skid=%0d got=%b exp=0", s, out_valid[s]); end
      end else begin
        checks++;
        if (out_valid[s] !== 1'b1 || out_data[s] !== d[k-1] || out_ctrl[s] !== 6'h21) begin
          errors++;
          $display("FAIL stream_out skid=%0d k=%0d got=%b/%h/%h exp=1/%h/21", s, k, out_valid[s], out_data[s], out_ctrl[s], d[k-1]);
        end
      end
      @(negedge clk);
    end
    #1;
    checks++;
    if (out_valid[s] !== 1'b0 || out_ctrl[s] !== '0) begin
      errors++; $display("FAIL stream_drain skid=%0d got=%b/%h exp=0/0", s, out_valid[s], out_ctrl[s]);
    end
  endtask

  task automatic test_skid();
    apply_reset(1);
    out_ready[1] = 1'b0;
    in_valid[1] = 1'b1; in_data[1] = 32'hA; in_ctrl[1] = 6'h15;
    #1;
    checks++; if (in_ready[1] !== 1'b1) begin errors++; $display("FAIL skid_rdy_empty got=%b exp=1", in_ready[1]); end
    @(negedge clk);
    in_data[1] = 32'hB; in_ctrl[1] = 6'h2A;
    #1;
    checks++; if (in_ready[1] !== 1'b1) begin errors++; $display("FAIL skid_rdy_one got=%b exp=1", in_ready[1]); end
    @(negedge clk);
    in_valid[1] = 1'b0;
    for (int k = 0; k < 2; k++) begin
      #1;
      checks++;
      if (in_ready[1] !== 1'b0 || out_valid[1] !== 1'b1 || out_data[1] !== 32'hA || out_ctrl[1] !== 6'h15) begin
        errors++;
        $display("FAIL skid_stall k=%0d got rdy=%b v=%b d=%h c=%h exp rdy=0 v=1 d=a c=15", k, in_ready[1], out_valid[1], out_data[1], out_ctrl[1]);
      end
      @(negedge clk);
    end
    out_ready[1] = 1'b1;
    #1;
    checks++; if (in_ready[1] !== 1'b0) begin errors++; $display("FAIL skid_rdy_comb_path got=%b exp=0", in_ready[1]); end
    @(negedge clk); #1;
    checks++;
    if (out_valid[1] !== 1'b1 || out_data[1] !== 32'hB || out_ctrl[1] !== 6'h2A || in_ready[1] !== 1'b1) begin
      errors++;
      $display("FAIL skid_second got v=%b d=%h c=%h rdy=%b exp v=1 d=b c=2a rdy=1", out_valid[1], out_data[1], out_ctrl[1], in_ready[1]);
    end
    @(negedge clk); #1;
    checks++;
    if (out_valid[1] !== 1'b0 || out_ctrl[1] !== '0) begin
      errors++; $display("FAIL skid_drain got=%b/%h exp=0/0", out_valid[1], out_ctrl[1]);
    end
  endtask

  task automatic test_flush(input int s);
    apply_reset(s);
    out_ready[s] = 1'b0;
    in_valid[s] = 1'b1; in_data[s] = 32'hA; in_ctrl[s] = 6'h15;
    @(negedge clk);
    if (s == 1) begin
      in_data[s] = 32'hB; in_ctrl[s] = 6'h2A;
      @(negedge clk);
    end
    in_valid[s] = 1'b1; in_data[s] = 32'hC; in_ctrl[s] = 6'h3F;
    flush[s] = 1'b1; out_ready[s] = (s == 0);
    #1;
    checks++;
    if (out_valid[s] !== 1'b1 || out_data[s] !== 32'hA) begin
      errors++; $display("FAIL flush_pre skid=%0d got=%b/%h exp=1/a", s, out_valid[s], out_data[s]);
    end
    @(negedge clk);
    flush[s] = 1'b0; in_valid[s] = 1'b0; out_ready[s] = 1'b1;
    #1;
    checks++;
    if (out_valid[s] !== 1'b0 || out_ctrl[s] !== '0 || in_ready[s] !== 1'b1 || out_data[s] !== 32'hA) begin
      errors++;
      $display("FAIL flush_post skid=%0d got v=%b c=%h rdy=%b d=%h exp v=0 c=0 rdy=1 d=a", s, out_valid[s], out_ctrl[s], in_ready[s], out_data[s]);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); #1;
      checks++;
      if (out_valid[s] !== 1'b0) begin errors++; $display("FAIL flush_leak skid=%0d k=%0d got=%b exp=0 d=%h", s, k, out_valid[s], out_data[s]); end
    end
  endtask

  task automatic test_flush_reset(input int s);
    apply_reset(s);
    out_ready[s] = 1'b0;
    in_valid[s] = 1'b1; in_data[s] = 32'h55; in_ctrl[s] = 6'h15;
    @(negedge clk);
    in_data[s] = 32'h66; in_ctrl[s] = 6'h2A;
    @(negedge clk);
    rst[s] = 1'b1; flush[s] = 1'b1; in_data[s] = 32'h77;
    @(negedge clk);
    rst[s] = 1'b0; flush[s] = 1'b0; in_valid[s] = 1'b0;
    #1;
    checks++;
    if (out_valid[s] !== 1'b0 || out_ctrl[s] !== '0 || out_data[s] !== '0 || in_ready[s] !== 1'b1) begin
      errors++;
      $display("FAIL flush_reset skid=%0d got v=%b c=%h d=%h rdy=%b exp v=0 c=0 d=0 rdy=1", s, out_valid[s], out_ctrl[s], out_data[s], in_ready[s]);
    end
    out_ready[s] = 1'b1;
    @(negedge clk); #1;
    checks++;
    if (out_valid[s] !== 1'b0) begin errors++; $display("FAIL flush_reset_leak skid=%0d got=%b exp=0", s, out_valid[s]); end
  endtask

  task automatic test_random(input int s);
    logic [DW+CW-1:0] q [$];
    logic             exp_rdy;
    logic             acc;
    logic             em;
    int               p_in;
    int               p_out;
    apply_reset(s);
    q.delete();
    for (int i = 0; i < 10000; i++) begin
      checks++;
      if (out_valid[s] !== (q.size() > 0)) begin
        errors++; $display("FAIL rand_valid skid=%0d cyc=%0d got=%b exp=%b", s, i, out_valid[s], q.size() > 0);
      end
      if (q.size() > 0) begin
        checks++;
        if ({out_data[s], out_ctrl[s]} !== q[0]) begin
          errors++; $display("FAIL rand_data skid=%0d cyc=%0d got=%h exp=%h", s, i, {out_data[s], out_ctrl[s]}, q[0]);
        end
      end else begin
        checks++;
        if (out_ctrl[s] !== '0) begin errors++; $display("FAIL rand_ctrl_idle skid=%0d cyc=%0d got=%h exp=0", s, i, out_ctrl[s]); end
      end
      p_in  = 30 + 25 * ((i / 1500) % 3);
      p_out = 20 + 30 * ((i / 1100) % 3);
      in_valid[s]  = ($urandom_range(0, 99) < p_in);
      out_ready[s] = ($urandom_range(0, 99) < p_out);
      in_data[s]   = $urandom;
      in_ctrl[s]   = CW'($urandom_range(0, 63));
      #1;
      exp_rdy = (s == 1) ? (q.size() < 2) : (q.size() == 0 || out_ready[s]);
      checks++;
      if (in_ready[s] !== exp_rdy) begin
        errors++; $display("FAIL rand_rdy skid=%0d cyc=%0d got=%b exp=%b", s, i, in_ready[s], exp_rdy);
      end
      acc = in_valid[s] && exp_rdy;
      em  = out_ready[s] && (q.size() > 0);
      if (em) void'(q.pop_front());
      if (acc) q.push_back({in_data[s], in_ctrl[s]});
      @(negedge clk);
    end
    in_valid[s] = 1'b0; out_ready[s] = 1'b0;
  endtask

  initial begin
    for (int s = 0; s < 2; s++) begin
      rst[s] = 1'b1; flush[s] = 1'b0; in_valid[s] = 1'b0; out_ready[s] = 1'b0;
      in_data[s] = '0; in_ctrl[s] = '0;
    end
    for (int s = 0; s < 2; s++) begin
      test_reset(s);
      test_stream(s);
      test_flush(s);
      test_flush_reset(s);
      test_random(s);
    end
    test_skid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
